// File: rtl/if_fetch_stage.sv
// if_fetch_stage: RISC-V IF stage with PC, single-outstanding imem handshake, skid buffer and IF/ID register.
// Optional FETCH_PERF_CNT_EN adds fetch/drop performance counters.
module if_fetch_stage #(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_PC_IF,
    input  logic            stall_IF_ID,
    input  logic            flush_IF_ID,
    input  logic            redirect_en,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] ID_pc,
    output logic [XLEN-1:0] ID_instr,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_drop_cnt,
`endif
    output logic            ID_valid
);
    typedef enum logic [1:0] {REQ, WAIT, HOLD, DROP} state_e;
    state_e          state_q;
    logic [XLEN-1:0] pc_q, req_pc_q, hold_instr_q, hold_pc_q;
    logic [XLEN-1:0] id_pc_q, id_instr_q;
    logic            id_valid_q;
    logic            wait_rsp, flush_id, load_wait, load_hold, load;
    assign imem_req  = (state_q == REQ) && !stall_PC_IF && !redirect_en && !rst;
    assign imem_addr = pc_q;
    assign wait_rsp  = (state_q == WAIT) && imem_rvalid;
    assign flush_id  = flush_IF_ID || redirect_en;
    assign load_wait = !flush_id && !stall_IF_ID && wait_rsp;
    assign load_hold = !flush_id && !stall_IF_ID && (state_q == HOLD);
    assign load      = load_wait || load_hold;
    assign ID_pc     = id_pc_q;
    assign ID_instr  = id_instr_q;
    assign ID_valid  = id_valid_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= REQ;
            pc_q         <= RESET_PC;
            req_pc_q     <= '0;
            hold_instr_q <= NOP_INSTR;
            hold_pc_q    <= '0;
            id_pc_q      <= '0;
            id_instr_q   <= NOP_INSTR;
            id_valid_q   <= 1'b0;
        end else begin
            case (state_q)
                REQ: if (imem_req && imem_gnt) begin
                    req_pc_q <= pc_q;
                    pc_q     <= pc_q + XLEN'(4);
                    state_q  <= WAIT;
                end
                WAIT: if (imem_rvalid) begin
                    state_q      <= (stall_IF_ID && !redirect_en) ? HOLD : REQ;
                    hold_instr_q <= imem_rdata;
                    hold_pc_q    <= req_pc_q;
                end else if (redirect_en) begin
                    state_q <= DROP;
                end
                HOLD: if (redirect_en || !stall_IF_ID) state_q <= REQ;
                DROP: if (imem_rvalid) state_q <= REQ;
            endcase
            // redirect overrides any increment from a grant (which cannot coincide anyway)
            if (redirect_en) pc_q <= redirect_pc;
            if (flush_id) begin
                id_valid_q <= 1'b0;
                id_instr_q <= NOP_INSTR;
            end else if (!stall_IF_ID) begin
                id_valid_q <= load;
                id_instr_q <= load_wait ? imem_rdata : load_hold ? hold_instr_q : NOP_INSTR;
                if (load) id_pc_q <= load_wait ? req_pc_q : hold_pc_q;
            end
        end
    end
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, drop_cnt_q;
    logic        drop;
    assign drop = (redirect_en && (wait_rsp || state_q == HOLD)) || (state_q == DROP && imem_rvalid);
    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_drop_cnt  = drop_cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_q + 32'(load);
            drop_cnt_q  <= drop_cnt_q + 32'(drop);
        end
    end
`endif
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed bench with a transaction-level fetch model and memory responder.
module tb_if_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic        clk = 1'b0, rst = 1'b1;
    logic        stall_PC_IF = 0, stall_IF_ID = 0, flush_IF_ID = 0, redirect_en = 0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req, imem_gnt = 0, imem_rvalid = 0;
    logic [31:0] imem_addr, imem_rdata = '0;
    logic [31:0] ID_pc, ID_instr;
    logic        ID_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_drop_cnt;
`endif
    always #5 clk = ~clk;
    if_fetch_stage dut (
        .clk(clk), .rst(rst), .stall_PC_IF(stall_PC_IF), .stall_IF_ID(stall_IF_ID),
        .flush_IF_ID(flush_IF_ID), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .ID_pc(ID_pc), .ID_instr(ID_instr),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetch_cnt(perf_fetch_cnt), .perf_drop_cnt(perf_drop_cnt),
`endif
        .ID_valid(ID_valid)
    );
    int n_chk = 0, n_fail = 0;
    bit c_rst = 1, c_spc = 0, c_sid = 0, c_fl = 0, c_rd = 0, c_gnt = 1;
    logic [31:0] c_rpc = '0;
    int c_lat = 1;
    bit mb = 0;
    logic [31:0] maddr = '0;
    int mcnt = 0;
    bit m_out, m_kill, m_held, m_v;
    logic [31:0] m_pc, m_rpc, m_hpc, m_hins, m_ipc, m_ins, m_fc, m_dc;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask
    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a == 0) ? 32'h0050_0093 : {a[19:0], 12'h013};
    endfunction
    task automatic model_reset();
        m_out = 0; m_kill = 0; m_held = 0; m_v = 0;
        m_pc = '0; m_rpc = '0; m_hpc = '0; m_hins = NOP; m_ipc = '0; m_ins = NOP;
        m_fc = '0; m_dc = '0;
    endtask
    // Transaction view: is a response owed (and is it wanted), is an instruction parked.
    task automatic model_step();
        bit ereq, fire, dlv, good;
        ereq = !m_out && !m_held && !stall_PC_IF && !redirect_en;
        fire = ereq && imem_gnt;
        dlv  = m_out && imem_rvalid;
        good = dlv && !m_kill;
        if (flush_IF_ID || redirect_en) begin
            m_v = 0; m_ins = NOP;
        end else if (!stall_IF_ID) begin
            if (good) begin
                m_v = 1; m_ipc = m_rpc; m_ins = imem_rdata; m_fc++;
            end else if (m_held) begin
                m_v = 1; m_ipc = m_hpc; m_ins = m_hins; m_fc++;
            end else begin
                m_v = 0; m_ins = NOP;
            end
        end
        if (dlv && (m_kill || redirect_en)) m_dc++;
        if (m_held && redirect_en) m_dc++;
        if (redirect_en) begin
            m_pc = redirect_pc; m_held = 0;
            m_kill = m_out && !dlv; m_out = m_kill;
        end else begin
            if (fire) begin
                m_out = 1; m_kill = 0; m_rpc = m_pc; m_pc = m_pc + 4;
            end
            if (dlv) begin
                m_out = 0;
                if (!m_kill && stall_IF_ID) begin
                    m_held = 1; m_hpc = m_rpc; m_hins = imem_rdata;
                end
                m_kill = 0;
            end else if (m_held && !stall_IF_ID) begin
                m_held = 0;
            end
        end
    endtask
    task automatic cyc();
        bit ereq;
        @(negedge clk);
        rst = c_rst; stall_PC_IF = c_spc; stall_IF_ID = c_sid; flush_IF_ID = c_fl;
        redirect_en = c_rd; redirect_pc = c_rpc;
        imem_rvalid = 0; imem_rdata = 32'hdead_beef;
        if (mb) begin
            if (mcnt == 0) begin
                imem_rvalid = 1; imem_rdata = memf(maddr); mb = 0;
            end else mcnt--;
        end
        imem_gnt = c_gnt && !mb;
        if (rst) model_reset();
        #1;
        ereq = !rst && !m_out && !m_held && !stall_PC_IF && !redirect_en;
        chk("imem_req", imem_req, ereq);
        if (ereq) chk("imem_addr", imem_addr, m_pc);
        chk("ID_valid", ID_valid, m_v);
        chk("ID_instr", ID_instr, m_ins);
        if (m_v) chk("ID_pc", ID_pc, m_ipc);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetch", perf_fetch_cnt, m_fc);
        chk("perf_drop", perf_drop_cnt, m_dc);
`endif
        if (!rst && imem_req && imem_gnt) begin
            mb = 1; maddr = imem_addr; mcnt = c_lat - 1;
        end
        if (!rst) model_step();
    endtask
    initial begin
        model_reset();
        cyc(); cyc();
        chk("rst_req", imem_req, 0);
        chk("rst_valid", ID_valid, 0);
        chk("rst_instr", ID_instr, NOP);
        chk("rst_pc", ID_pc, 0);
        c_rst = 0;
        cyc();
        chk("first_req", imem_req, 1);
        chk("first_addr", imem_addr, 32'h0);
        cyc(); cyc();
        chk("first_valid", ID_valid, 1);
        chk("first_pc", ID_pc, 32'h0);
        chk("first_instr", ID_instr, 32'h0050_0093);
        chk("second_addr", imem_addr, 32'h4);
        cyc();
        c_spc = 1;
        repeat (3) begin
            cyc();
            chk("stall_pc_req", imem_req, 0);
            chk("stall_pc_addr", imem_addr, 32'h8);
        end
        c_spc = 0;
        cyc();
        chk("post_stall_req", imem_req, 1);
        chk("post_stall_addr", imem_addr, 32'h8);
        chk("post_stall_valid", ID_valid, 0);
        c_sid = 1;
        cyc(); cyc();
        chk("hold_req", imem_req, 0);
        chk("hold_valid", ID_valid, 0);
        c_sid = 0;
        cyc();
        c_lat = 3;
        cyc();
        chk("unhold_valid", ID_valid, 1);
        chk("unhold_pc", ID_pc, 32'h8);
        chk("unhold_instr", ID_instr, 32'h0000_8013);
        chk("unhold_next_req", imem_req, 1);
        chk("unhold_next_addr", imem_addr, 32'hC);
        c_rd = 1; c_rpc = 32'h100;
        cyc();
        c_rd = 0;
        cyc();
        chk("drop_req", imem_req, 0);
        cyc();
        chk("drop_rsp_req", imem_req, 0);
        chk("drop_rsp_valid", ID_valid, 0);
        c_lat = 1;
        cyc();
        chk("redir_req", imem_req, 1);
        chk("redir_addr", imem_addr, 32'h100);
        chk("redir_valid", ID_valid, 0);
        cyc();
        c_fl = 1; c_sid = 1;
        cyc();
        chk("redir_id_valid", ID_valid, 1);
        chk("redir_id_pc", ID_pc, 32'h100);
        chk("redir_id_instr", ID_instr, 32'h0010_0013);
        c_fl = 0; c_sid = 0;
        cyc();
        chk("flush_valid", ID_valid, 0);
        chk("flush_instr", ID_instr, 32'h0000_0013);
        c_lat = 4;
        cyc();
        chk("after_flush_pc", ID_pc, 32'h104);
        c_rst = 1; c_gnt = 0;
        cyc();
        chk("midrst_req", imem_req, 0);
        chk("midrst_valid", ID_valid, 0);
        c_rst = 0;
        cyc();
        chk("rerst_req", imem_req, 1);
        chk("rerst_addr", imem_addr, 32'h0);
        cyc(); cyc();
        chk("stale_valid", ID_valid, 0);
        c_gnt = 1; c_lat = 1;
        cyc();
        chk("stale_ignored", ID_valid, 0);
        chk("refetch_addr", imem_addr, 32'h0);
        cyc(); cyc();
        chk("refetch_valid", ID_valid, 1);
        chk("refetch_pc", ID_pc, 32'h0);
        chk("refetch_instr", ID_instr, 32'h0050_0093);
        for (int i = 0; i < 300; i++) begin
            c_spc = (i % 5 == 2);
            c_sid = (i % 7 == 3) || (i % 7 == 4);
            c_rd  = (i % 13 == 6);
            c_rpc = 32'h200 + 32'(i) * 8;
            c_fl  = c_rd || ((i % 17 == 9) && c_sid);
            c_gnt = (i % 4 != 1);
            c_lat = 1 + i % 3;
            cyc();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
